// File: rtl/task2_18_mux.sv
// task2_18_mux: registered A>B>C priority bus selector with contention flag and saturating contention counter.
// Counter is present only when TASK2_18_CONFLICT_CNT_EN is defined; otherwise conflict_cnt reads 0.
module task2_18_mux #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    input  logic                 selA,
    input  logic                 selB,
    input  logic                 selC,
    output logic [WIDTH-1:0]     Z,
    output logic                 valid,
    output logic                 conflict,
    output logic [CNT_WIDTH-1:0] conflict_cnt
);
    logic [WIDTH-1:0] z_q, z_d;
    logic             valid_q, valid_d, conflict_q, conflict_d;
    always_comb begin
        z_d        = selA ? A : selB ? B : selC ? C : '0;
        valid_d    = selA | selB | selC;
        conflict_d = (selA & selB) | (selA & selC) | (selB & selC);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            z_q        <= '0;
            valid_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            z_q        <= z_d;
            valid_q    <= valid_d;
            conflict_q <= conflict_d;
        end
    end
    assign Z        = z_q;
    assign valid    = valid_q;
    assign conflict = conflict_q;
`ifdef TASK2_18_CONFLICT_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Holds at all-ones instead of wrapping.
    assign cnt_d = (conflict_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_task2_18_mux.sv
// tb_task2_18_mux: directed plus random stimulus for task2_18_mux against a behavioural model.
module tb_task2_18_mux;
    localparam int W  = 8;
    localparam int CW = 8;
    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  A, B, C;
    logic          selA, selB, selC;
    logic [W-1:0]  Z;
    logic          valid, conflict;
    logic [CW-1:0] conflict_cnt;
    int tests = 0;
    int fails = 0;
    logic [W-1:0]  exp_z;
    logic          exp_v, exp_c;
    int            exp_cnt = 0;

    task2_18_mux #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
        .selA(selA), .selB(selB), .selC(selC),
        .Z(Z), .valid(valid), .conflict(conflict), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [2:0] sel, input logic r, input string tag);
        logic [W-1:0] src [3];
        int n;
        A = a; B = b; C = c;
        {selA, selB, selC} = sel;
        rst = r;
        src[0] = c; src[1] = b; src[2] = a;
        n = $countones(sel);
        @(posedge clk);
        if (r) begin
            exp_z = '0; exp_v = 1'b0; exp_c = 1'b0; exp_cnt = 0;
        end else begin
            exp_z = '0;
            for (int i = 0; i < 3; i++) if (sel[i]) exp_z = src[i];
            exp_v = (n >= 1);
            exp_c = (n >= 2);
`ifdef TASK2_18_CONFLICT_CNT_EN
            if (exp_c && exp_cnt < (1 << CW) - 1) exp_cnt = exp_cnt + 1;
`endif
        end
        #1;
        tests++;
        assert (Z === exp_z) else begin
            fails++; $error("FAIL %s z: got %h expected %h", tag, Z, exp_z);
        end
        tests++;
        assert (valid === exp_v) else begin
            fails++; $error("FAIL %s valid: got %b expected %b", tag, valid, exp_v);
        end
        tests++;
        assert (conflict === exp_c) else begin
            fails++; $error("FAIL %s conflict: got %b expected %b", tag, conflict, exp_c);
        end
        tests++;
        assert (conflict_cnt === CW'(exp_cnt)) else begin
            fails++; $error("FAIL %s cnt: got %0d expected %0d", tag, conflict_cnt, exp_cnt);
        end
    endtask

    initial begin
        step(8'h11, 8'h22, 8'h33, 3'b111, 1'b1, "reset0");
        step(8'h11, 8'h22, 8'h33, 3'b111, 1'b1, "reset1");
        step(8'hA5, 8'h5A, 8'h3C, 3'b001, 1'b0, "selC");
        step(8'hA5, 8'h5A, 8'h3C, 3'b010, 1'b0, "selB");
        step(8'hA5, 8'h5A, 8'h3C, 3'b100, 1'b0, "selA");
        for (int s = 0; s < 8; s++) step(8'd1, 8'd2, 8'd3, 3'(s), 1'b0, "walk");
`ifdef TASK2_18_CONFLICT_CNT_EN
        tests++;
        assert (conflict_cnt === 8'd4) else begin
            fails++; $error("FAIL walk_cnt: got %0d expected 4", conflict_cnt);
        end
`endif
        for (int s = 0; s < 8; s++) step(8'd0, 8'd0, 8'd0, 3'(s), 1'b0, "zero");
        step(8'h10, 8'h20, 8'h30, 3'b100, 1'b0, "unsel0");
        step(8'h10, 8'hEE, 8'hDD, 3'b100, 1'b0, "unsel1");
        for (int i = 0; i < 200; i++)
            step(W'($urandom), W'($urandom), W'($urandom), 3'($urandom), 1'b0, "rand");
        for (int i = 0; i < 300; i++) step(8'h44, 8'h55, 8'h66, 3'b110, 1'b0, "sat");
        tests++;
`ifdef TASK2_18_CONFLICT_CNT_EN
        assert (conflict_cnt === 8'd255) else begin
            fails++; $error("FAIL sat_cnt: got %0d expected 255", conflict_cnt);
        end
`else
        assert (conflict_cnt === 8'd0) else begin
            fails++; $error("FAIL sat_cnt: got %0d expected 0", conflict_cnt);
        end
`endif
        step(8'hAA, 8'hBB, 8'hCC, 3'b010, 1'b0, "lat_b");
        step(8'hAA, 8'hBB, 8'hCC, 3'b100, 1'b0, "lat_a");
        step(8'hAA, 8'hBB, 8'hCC, 3'b111, 1'b1, "mid_rst");
        step(8'hAA, 8'hBB, 8'hCC, 3'b011, 1'b0, "resume");
        for (int i = 0; i < 50; i++)
            step(W'($urandom), W'($urandom), W'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0), "rand_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/task2_18_mux.md
Name: task2_18_mux

Overview:
- Registered 3-input priority bus selector: drives Z from A, B or C according to select lines selA/selB/selC.
- Flags cycles where more than one select is asserted, i.e. bus contention.
- Used as the shared-bus source mux in the task2 datapath; one clock domain.

Parameters:
- WIDTH, 8, data width of A, B, C and Z.
- CNT_WIDTH, 8, width of the contention event counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- A  input  WIDTH  source A data.
- B  input  WIDTH  source B data.
- C  input  WIDTH  source C data.
- selA  input  1  select source A (highest priority).
- selB  input  1  select source B.
- selC  input  1  select source C (lowest priority).
- Z  output  WIDTH  registered selected data.
- valid  output  1  registered: at least one select was asserted.
- conflict  output  1  registered: two or more selects were asserted.
- conflict_cnt  output  CNT_WIDTH  saturating count of contention cycles.

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1: Z=0, valid=0, conflict=0, conflict_cnt=0. Reset overrides all inputs.
- Selection is fixed priority A > B > C:
  - selA=1 gives next Z=A.
  - Else selB=1 gives next Z=B.
  - Else selC=1 gives next Z=C.
  - Else next Z=0.
- Latency is 1 cycle. Inputs sampled at edge N appear on Z/valid/conflict after edge N; there is no combinational input-to-output path.
- valid = selA|selB|selC, registered alongside Z.
- conflict = 1 when the popcount of {selA,selB,selC} is ≥2. Z still follows priority during conflict; no X or OR-ing of sources.
- conflict_cnt increments by 1 on each edge where conflict is detected. It saturates at 2^CNT_WIDTH-1 and never wraps. It clears only on reset.
- All 8 select combinations are legal. For 3'b000 (selA,selB,selC): Z=0, valid=0, conflict=0.
- Data inputs are not latched when unselected. A change on an unselected source does not affect Z.
- If reset is asserted mid-stream, outputs are 0 on the following cycle. Normal operation resumes on the first edge after rst deasserts.

Optional Feature:
- Macro: TASK2_18_CONFLICT_CNT_EN.
- Defined: conflict_cnt counter implemented as above.
- Undefined: counter logic omitted. conflict_cnt is tied to 0, the port remains present, and the conflict flag is still produced.

Test Plan:
- Reset: drive A=8'h11,B=8'h22,C=8'h33, all selects=1, rst=1 for 2 cycles → Z=0, valid=0, conflict=0, conflict_cnt=0.
- Single selects with A=8'hA5,B=8'h5A,C=8'h3C:
  - selC only → Z=8'h3C next cycle.
  - selB only → Z=8'h5A.
  - selA only → Z=8'hA5.
  - In all three cases valid=1, conflict=0.
- Priority/contention: walk all 8 combinations of {selA,selB,selC} with A=1,B=2,C=3:
  - 000 → Z=0, valid=0.
  - 001 → 3.
  - 010 → 2.
  - 011 → 2 with conflict=1.
  - 100 → 1.
  - 101, 110, 111 → 1 with conflict=1.
  - conflict_cnt=4 at end (macro defined).
- Zero data: A=B=C=0 across all 8 select combinations → Z=0 throughout; valid and conflict follow the select pattern.
- Saturation: hold selA=selB=1 for 300 cycles (CNT_WIDTH=8) → conflict_cnt stops at 255 and stays.
- Latency/reset mid-run: change selB→selA on edge N → Z switches exactly one cycle later. Then assert rst for one cycle mid-stream → next cycle all outputs 0. Operation resumes the cycle after rst falls.
